// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC and the fetch FSM state encoding.
package cpu_pkg;

  localparam int N = 32;
  localparam int M = 16;
  localparam logic [M-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decoder handshake and branch/halt feedback.
interface fetch_unit_if #(
  parameter int N = cpu_pkg::N,
  parameter int M = cpu_pkg::M
);

  logic         imem_req;
  logic [M-1:0] imem_addr;
  logic         imem_valid;
  logic [N-1:0] imem_rdata;
  logic [N-1:0] instr;
  logic         instr_valid;
  logic         instr_ready;
  logic [M-1:0] pc;
  logic         is_jz;
  logic         is_jg;
  logic         flag_zero;
  logic         flag_greater;
  logic [M-1:0] jump_target;
  logic         is_halted;
  logic         halted;

  // master is the fetch unit; slave is the memory/decoder side
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, halted,
    input  imem_valid, imem_rdata, instr_ready, is_jz, is_jg,
           flag_zero, flag_greater, jump_target, is_halted
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, halted,
    output imem_valid, imem_rdata, instr_ready, is_jz, is_jg,
           flag_zero, flag_greater, jump_target, is_halted
  );

endinterface

// File: rtl/next_pc.sv
// Next-PC selection: conditional jz/jg branch resolution with modulo-2^M sequential increment.
module next_pc #(
  parameter int M = cpu_pkg::M
) (
  input  logic [M-1:0] i_pc,
  input  logic [M-1:0] i_jump_target,
  input  logic         i_is_jz,
  input  logic         i_is_jg,
  input  logic         i_flag_zero,
  input  logic         i_flag_greater,
  output logic [M-1:0] o_next_pc
);

  logic w_taken;

  // jz and jg share one target, so either condition alone is enough to take it
  always_comb begin
    w_taken   = (i_is_jz && i_flag_zero) || (i_is_jg && i_flag_greater);
    o_next_pc = w_taken ? i_jump_target : i_pc + 1'b1;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word read, valid/ready hand-off to decode, branch and halt handling.
module fetch_unit #(
  parameter int           N        = cpu_pkg::N,
  parameter int           M        = cpu_pkg::M,
  parameter logic [M-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  import cpu_pkg::*;

  fetch_state_t r_state, w_state_nxt;
  logic [M-1:0] r_pc, w_pc_nxt;
  logic [M-1:0] r_addr, w_addr_nxt;
  logic [N-1:0] r_instr, w_instr_nxt;
  logic         r_req, w_req_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_halted, w_halted_nxt;
  logic [M-1:0] w_branch_pc;
  logic         w_handshake;

  next_pc #(.M(M)) u_next_pc (
    .i_pc           (r_pc),
    .i_jump_target  (bus.jump_target),
    .i_is_jz        (bus.is_jz),
    .i_is_jg        (bus.is_jg),
    .i_flag_zero    (bus.flag_zero),
    .i_flag_greater (bus.flag_greater),
    .o_next_pc      (w_branch_pc)
  );

  assign w_handshake = r_valid && bus.instr_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_addr_nxt   = r_addr;
    w_instr_nxt  = r_instr;
    w_req_nxt    = 1'b0;
    w_valid_nxt  = r_valid;
    w_halted_nxt = r_halted;
    unique case (r_state)
      S_REQ: begin
        w_req_nxt   = 1'b1;
        w_addr_nxt  = r_pc;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_valid) begin
          w_instr_nxt = bus.imem_rdata;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // halt wins over any branch decoded on the same instruction
        if (w_handshake) begin
          w_valid_nxt = 1'b0;
          if (bus.is_halted) begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = S_HALT;
          end else begin
            w_pc_nxt    = w_branch_pc;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HALT: begin
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b1;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_addr   <= '0;
      r_instr  <= '0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_addr   <= w_addr_nxt;
      r_instr  <= w_instr_nxt;
      r_req    <= w_req_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.pc          = r_pc;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, branches, PC wrap, halt and reset-in-wait.
module tb_fetch_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.N(32), .M(16)) bus0 ();
  fetch_unit_if #(.N(32), .M(16)) bus1 ();

  fetch_unit #(.N(32), .M(16), .RESET_PC(16'h0000)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  fetch_unit #(.N(32), .M(16), .RESET_PC(16'hFFFF)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // memory models: one-cycle latency, data = 0x1111_0000 | address
  logic        mem_en0    = 1'b1;
  logic        spur0      = 1'b0;
  logic [31:0] spur_data0 = 32'h0;
  logic        pend0      = 1'b0;
  logic        pend1      = 1'b0;
  logic [15:0] paddr0     = 16'h0;
  logic [15:0] paddr1     = 16'h0;
  logic [15:0] last_addr0 = 16'h0;
  logic [15:0] last_addr1 = 16'h0;
  int          req_cnt0   = 0;

  always @(posedge clk) begin
    pend0  <= mem_en0 && bus0.imem_req;
    paddr0 <= bus0.imem_addr;
    if (bus0.imem_req) begin
      req_cnt0   <= req_cnt0 + 1;
      last_addr0 <= bus0.imem_addr;
    end
    pend1  <= bus1.imem_req;
    paddr1 <= bus1.imem_addr;
    if (bus1.imem_req) last_addr1 <= bus1.imem_addr;
  end

  assign bus0.imem_valid = pend0 | spur0;
  assign bus0.imem_rdata = pend0 ? (32'h1111_0000 | {16'h0, paddr0}) : spur_data0;
  assign bus1.imem_valid = pend1;
  assign bus1.imem_rdata = 32'h1111_0000 | {16'h0, paddr1};

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb0[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   rc       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid0(input string tag);
    int i;
    i = 0;
    while (bus0.instr_valid !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check({tag, " valid_timeout"}, 32'(bus0.instr_valid), 32'd1);
  endtask

  task automatic expect0(input logic [15:0] p);
    sb0.push_back({p, 32'h1111_0000 | {16'h0, p}});
  endtask

  task automatic pop_check0(input string tag);
    exp_t e;
    wait_valid0(tag);
    check({tag, " sb_nonempty"}, 32'(sb0.size() > 0), 32'd1);
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      check({tag, " instr"}, bus0.instr, e.instr);
      check({tag, " pc"}, {16'h0, bus0.pc}, {16'h0, e.pc});
    end
  endtask

  // with ready high the handshake completes on the posedge before the next negedge
  task automatic fetch0(input logic [15:0] p, input string tag);
    expect0(p);
    pop_check0(tag);
    @(negedge clk);
  endtask

  initial begin
    bus0.instr_ready  = 1'b1;
    bus0.is_jz        = 1'b0;
    bus0.is_jg        = 1'b0;
    bus0.flag_zero    = 1'b0;
    bus0.flag_greater = 1'b0;
    bus0.jump_target  = 16'h0;
    bus0.is_halted    = 1'b0;
    bus1.instr_ready  = 1'b0;
    bus1.is_jz        = 1'b0;
    bus1.is_jg        = 1'b0;
    bus1.flag_zero    = 1'b0;
    bus1.flag_greater = 1'b0;
    bus1.jump_target  = 16'h0;
    bus1.is_halted    = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst instr", bus0.instr, 32'h0);
    check("rst instr_valid", 32'(bus0.instr_valid), 32'd0);
    check("rst imem_req", 32'(bus0.imem_req), 32'd0);
    check("rst imem_addr", {16'h0, bus0.imem_addr}, 32'h0);
    check("rst halted", 32'(bus0.halted), 32'd0);
    check("rst pc", {16'h0, bus0.pc}, 32'h0);
    check("rst wrap pc", {16'h0, bus1.pc}, 32'h0000_FFFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // sequential fetch, one request per instruction
    rc = req_cnt0;
    fetch0(16'h0, "seq0");
    check("seq0 reqs", 32'(req_cnt0 - rc), 32'd1);
    fetch0(16'h1, "seq1");
    check("seq1 reqs", 32'(req_cnt0 - rc), 32'd2);
    fetch0(16'h2, "seq2");
    check("seq2 reqs", 32'(req_cnt0 - rc), 32'd3);

    // backpressure
    bus0.instr_ready = 1'b0;
    expect0(16'h3);
    pop_check0("bp");
    rc = req_cnt0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp instr stable", bus0.instr, 32'h1111_0003);
      check("bp pc stable", {16'h0, bus0.pc}, 32'h3);
      check("bp valid stable", 32'(bus0.instr_valid), 32'd1);
    end
    check("bp no req", 32'(req_cnt0 - rc), 32'd0);
    bus0.instr_ready = 1'b1;
    @(negedge clk);

    // jz taken at pc 4
    bus0.is_jz       = 1'b1;
    bus0.flag_zero   = 1'b1;
    bus0.jump_target = 16'h0020;
    fetch0(16'h4, "pc4");
    bus0.is_jz       = 1'b0;
    bus0.flag_zero   = 1'b0;
    // jg not taken at 0x20
    bus0.is_jg        = 1'b1;
    bus0.flag_greater = 1'b0;
    bus0.jump_target  = 16'h0040;
    fetch0(16'h20, "jz_taken");
    check("jz_taken addr", {16'h0, last_addr0}, 32'h20);
    // both jz and jg set, only the greater condition holds
    bus0.is_jz        = 1'b1;
    bus0.flag_greater = 1'b1;
    bus0.jump_target  = 16'h0030;
    fetch0(16'h21, "jg_not_taken");
    check("jg_not_taken addr", {16'h0, last_addr0}, 32'h21);
    bus0.is_jz        = 1'b0;
    bus0.is_jg        = 1'b0;
    bus0.flag_greater = 1'b0;

    // halt takes priority over a taken branch on the same instruction
    bus0.is_halted   = 1'b1;
    bus0.is_jz       = 1'b1;
    bus0.flag_zero   = 1'b1;
    bus0.jump_target = 16'h0050;
    expect0(16'h30);
    pop_check0("both_taken");
    rc = req_cnt0;
    @(negedge clk);
    check("halt halted", 32'(bus0.halted), 32'd1);
    check("halt instr_valid", 32'(bus0.instr_valid), 32'd0);
    bus0.is_halted = 1'b0;
    bus0.is_jz     = 1'b0;
    bus0.flag_zero = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      spur0      = (i % 5 == 0);
      spur_data0 = 32'hBAD0_0000 + 32'(i);
    end
    spur0 = 1'b0;
    @(negedge clk);
    check("halt no req", 32'(req_cnt0 - rc), 32'd0);
    check("halt sticky", 32'(bus0.halted), 32'd1);
    check("halt valid low", 32'(bus0.instr_valid), 32'd0);
    check("halt pc", {16'h0, bus0.pc}, 32'h30);

    // PC wrap on the second instance, parked in HOLD at 0xFFFF since reset
    check("wrap first pc", {16'h0, bus1.pc}, 32'h0000_FFFF);
    check("wrap first instr", bus1.instr, 32'h1111_FFFF);
    bus1.instr_ready = 1'b1;
    @(negedge clk);
    bus1.instr_ready = 1'b0;
    for (int i = 0; i < 50 && bus1.instr_valid !== 1'b1; i++) @(negedge clk);
    check("wrap valid", 32'(bus1.instr_valid), 32'd1);
    check("wrap second addr", {16'h0, last_addr1}, 32'h0);
    check("wrap second pc", {16'h0, bus1.pc}, 32'h0);
    check("wrap second instr", bus1.instr, 32'h1111_0000);

    // reset while a read is outstanding, then a stale response
    mem_en0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2 halted", 32'(bus0.halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10 && bus0.imem_req !== 1'b1; i++) @(negedge clk);
    check("rstw req seen", 32'(bus0.imem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstw pc", {16'h0, bus0.pc}, 32'h0);
    check("rstw valid", 32'(bus0.instr_valid), 32'd0);
    check("rstw req", 32'(bus0.imem_req), 32'd0);
    check("rstw instr", bus0.instr, 32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    spur0      = 1'b1;
    spur_data0 = 32'hDEAD_BEEF;
    mem_en0    = 1'b1;
    rc         = req_cnt0;
    @(negedge clk);
    spur0 = 1'b0;
    check("rstw stale ignored", 32'(bus0.instr_valid), 32'd0);
    fetch0(16'h0, "rstw fresh0");
    check("rstw fresh reqs", 32'(req_cnt0 - rc), 32'd1);
    fetch0(16'h1, "rstw fresh1");
    fetch0(16'h2, "rstw fresh2");
    bus0.is_halted = 1'b1;
    expect0(16'h3);
    pop_check0("halt3");
    @(negedge clk);
    bus0.is_halted = 1'b0;
    check("halt3 halted", 32'(bus0.halted), 32'd1);
    check("halt3 valid", 32'(bus0.instr_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage feeding the 32-bit CPU decode controller. Owns the program counter, issues one word-addressed read at a time to instruction memory, and presents the fetched word on a valid/ready handshake to the decoder. It resolves the next PC from the decoder's jz/jg outputs and condition flags, and stops fetching for good once the decoder reports halt.

Parameters:
N, 32, instruction width in bits
M, 16, address width in bits (word addressed)
RESET_PC, 0, PC value loaded at reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  one-cycle read request pulse
imem_addr  out  M  read address; valid while imem_req=1
imem_valid  in  1  read data valid, one cycle
imem_rdata  in  N  read data
instr  out  N  fetched instruction to decoder
instr_valid  out  1  instr holds a valid word
instr_ready  in  1  decoder accepts instr this cycle
pc  out  M  address of the word currently on instr (for pc_read)
is_jz  in  1  decoder: current instr is jz
is_jg  in  1  decoder: current instr is jg
flag_zero  in  1  execute zero flag
flag_greater  in  1  execute greater flag
jump_target  in  M  branch target of current instr
is_halted  in  1  decoder halt indication
halted  out  1  fetch stopped, sticky

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=S_REQ, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, imem_addr=0, halted=0.
- States:
  S_REQ: drive imem_req=1 and imem_addr=pc for exactly one cycle, then go to S_WAIT.
  S_WAIT: on imem_valid=1, latch imem_rdata into instr, set instr_valid=1, go to S_HOLD. With imem_valid=0, stay.
  S_HOLD: hold instr, pc and instr_valid=1 stable until instr_valid&&instr_ready. On that handshake cycle:
    - is_halted=1: go to S_HALT, instr_valid=0, halted=1. This check has priority over branches.
    - else taken = (is_jz&&flag_zero) || (is_jg&&flag_greater). Set pc <= taken ? jump_target : pc+1.
    - Then instr_valid=0 and go to S_REQ.
  S_HALT: absorbing until reset. No requests; imem_valid ignored; halted=1, instr_valid=0.
- is_jz, is_jg, flags, jump_target and is_halted are sampled only on the handshake cycle. They are don't-care otherwise.
- is_jz and is_jg both set: taken if either condition holds. Both share jump_target.
- PC arithmetic is M-bit modulo: 0xFFFF+1 wraps to 0x0000, with no flag.
- Only one request is outstanding at a time. imem_valid outside S_WAIT is ignored, including stale responses after reset.
- Latency: req at cycle t; imem_valid at t+k (k>=1); instr_valid at t+k+1. With ready held high, throughput is one instruction per 3+k-1 cycles minimum: REQ, WAIT, HOLD.
- Reset mid-operation (any state) aborts immediately. Outputs return to reset values asynchronously, and the first request issues on the first clock after deassertion.
- imem_req and instr_valid are registered outputs with no combinational path from inputs. instr_ready has no effect outside S_HOLD.

Decomposition:
- Shared package cpu_pkg: N, M, RESET_PC default, and the fetch state enum (S_REQ, S_WAIT, S_HOLD, S_HALT).
- One sub-module, next_pc: combinational taken/target selection with modulo increment. The FSM stays in fetch_unit.

Test Plan:
- Sequential fetch: memory returns 0x1111_0000+addr with 1-cycle latency, ready=1 -> instr sequence 0x11110000, 0x11110001, 0x11110002 with pc 0,1,2; imem_req pulses exactly once per instruction.
- Backpressure: ready=0 for 5 cycles in S_HOLD -> instr, pc and instr_valid stable; no imem_req until ready=1; then the next address is pc+1.
- Branches: at pc=4, is_jz=1, flag_zero=1, target=0x0020 -> next imem_addr=0x0020. At pc=0x20, is_jg=1, flag_greater=0 -> next imem_addr=0x0021.
- Wrap: RESET_PC=0xFFFF, ready=1 -> second request address is 0x0000.
- Halt: is_halted=1 with ready=1 at pc=3 -> halted=1 next cycle; instr_valid=0; no further imem_req over 20 cycles; spurious imem_valid ignored.
- Reset in S_WAIT: assert rst_n=0 mid-wait, then return imem_valid after deassertion -> stale data not presented; pc=RESET_PC; fresh request issued.
